// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester and memory-port bundle for mem_access_arbiter (ACCESS_COUNTER_EN adds counters)
interface mem_access_arbiter_if #(
    parameter int DW = 32
);
    logic          if_req_i;
    logic [DW-1:0] if_addr_i;
    logic          if_ack_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [DW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_ack_o;
    logic [DW-1:0] d_rdata_o;
    logic [DW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;
`ifdef ACCESS_COUNTER_EN
    logic [31:0]   if_cnt_o;
    logic [31:0]   d_cnt_o;
`endif

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        input  if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, mem_addr_o, mem_we_o, mem_wdata_o, busy_o
`ifdef ACCESS_COUNTER_EN
        , input if_cnt_o, d_cnt_o
`endif
    );

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        output if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, mem_addr_o, mem_we_o, mem_wdata_o, busy_o
`ifdef ACCESS_COUNTER_EN
        , output if_cnt_o, d_cnt_o
`endif
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - fetch/data arbiter for a single-port memory (ACCESS_COUNTER_EN adds access counters)
module mem_access_arbiter #(
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state;
    logic          owner_d;
    logic [3:0]    streak;
    logic [DW-1:0] mem_addr_r;
    logic          mem_we_r;
    logic [DW-1:0] mem_wdata_r;
    logic          if_ack_r;
    logic          d_ack_r;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] d_rdata_r;
    logic          grant_if;

    // Fetch wins when alone, or when data has held the port STARVE_LIMIT times in a row.
    assign grant_if = bus.if_req_i && (!bus.d_req_i || streak == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            streak      <= 4'd0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            if_ack_r    <= 1'b0;
            d_ack_r     <= 1'b0;
            if_rdata_r  <= '0;
            d_rdata_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req_i || bus.d_req_i) begin
                        state <= ACCESS;
                        if (grant_if) begin
                            owner_d     <= 1'b0;
                            mem_addr_r  <= bus.if_addr_i;
                            mem_we_r    <= 1'b0;
                            mem_wdata_r <= '0;
                            streak      <= 4'd0;
                        end else begin
                            owner_d     <= 1'b1;
                            mem_addr_r  <= bus.d_addr_i;
                            mem_we_r    <= bus.d_we_i;
                            mem_wdata_r <= bus.d_wdata_i;
                            if (!bus.if_req_i)
                                streak <= 4'd0;
                            else if (streak != LIMIT)
                                streak <= streak + 4'd1;
                        end
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    mem_addr_r  <= '0;
                    mem_we_r    <= 1'b0;
                    mem_wdata_r <= '0;
                    if_ack_r    <= !owner_d;
                    d_ack_r     <= owner_d;
                    if (!owner_d)
                        if_rdata_r <= bus.mem_rdata_i;
                    else if (!mem_we_r)
                        d_rdata_r <= bus.mem_rdata_i;
                end
                RESP: begin
                    state    <= IDLE;
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACCESS_COUNTER_EN
    logic [31:0] if_cnt_r;
    logic [31:0] d_cnt_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_cnt_r <= 32'd0;
            d_cnt_r  <= 32'd0;
        end else if (state == RESP) begin
            if (!owner_d && if_cnt_r != 32'hFFFF_FFFF)
                if_cnt_r <= if_cnt_r + 32'd1;
            if (owner_d && d_cnt_r != 32'hFFFF_FFFF)
                d_cnt_r <= d_cnt_r + 32'd1;
        end
    end

    assign bus.if_cnt_o = if_cnt_r;
    assign bus.d_cnt_o  = d_cnt_r;
`endif

    // Write enable is gated by reset directly so a store caught mid-access never lands.
    assign bus.mem_we_o    = mem_we_r & rst_n;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_wdata_o = mem_wdata_r;
    assign bus.if_ack_o    = if_ack_r;
    assign bus.d_ack_o     = d_ack_r;
    assign bus.if_rdata_o  = if_rdata_r;
    assign bus.d_rdata_o   = d_rdata_r;
    assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] mem [0:255];

    mem_access_arbiter_if #(.DW(32)) bus();

    mem_access_arbiter #(.DW(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];
    always @(posedge clk)
        if (bus.mem_we_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;

    task automatic run_access(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd, output bit seen);
        seen = 1'b0;
        rd   = '0;
        @(negedge clk);
        if (is_d) begin
            bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_addr_i = addr; bus.d_wdata_i = wdata;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = addr;
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (is_d && bus.d_ack_o) begin seen = 1'b1; rd = bus.d_rdata_o; end
            if (!is_d && bus.if_ack_o) begin seen = 1'b1; rd = bus.if_rdata_o; end
        end
        bus.if_req_i = 1'b0;
        bus.d_req_i  = 1'b0;
        bus.d_we_i   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_req_i = 0; bus.if_addr_i = '0;
        bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        total++; if (bus.mem_addr_o !== 32'h0 || bus.mem_we_o !== 1'b0 || bus.mem_wdata_o !== 32'h0) begin
            bad++; $display("FAIL reset_mem got addr=%h we=%b wdata=%h exp=0/0/0", bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o); end
        total++; if (bus.if_ack_o !== 1'b0 || bus.d_ack_o !== 1'b0) begin
            bad++; $display("FAIL reset_acks got if=%b d=%b exp=0/0", bus.if_ack_o, bus.d_ack_o); end
        total++; if (bus.if_rdata_o !== 32'h0 || bus.d_rdata_o !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got if=%h d=%h exp=0/0", bus.if_rdata_o, bus.d_rdata_o); end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h4;
        @(negedge clk);
        total++; if (bus.mem_addr_o !== 32'h4 || bus.mem_we_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL fetch_access got addr=%h we=%b busy=%b exp=4/0/1", bus.mem_addr_o, bus.mem_we_o, bus.busy_o); end
        total++; if (bus.if_ack_o !== 1'b0) begin bad++; $display("FAIL fetch_early_ack got=%b exp=0", bus.if_ack_o); end
        @(negedge clk);
        total++; if (bus.if_ack_o !== 1'b1 || bus.d_ack_o !== 1'b0) begin
            bad++; $display("FAIL fetch_ack got if=%b d=%b exp=1/0", bus.if_ack_o, bus.d_ack_o); end
        total++; if (bus.if_rdata_o !== 32'h20080005) begin
            bad++; $display("FAIL fetch_rdata got=%h exp=20080005", bus.if_rdata_o); end
        total++; if (bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL fetch_resp_addr got=%h exp=0", bus.mem_addr_o); end
        bus.if_req_i = 1'b0;
        @(negedge clk);
        total++; if (bus.if_ack_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.if_rdata_o !== 32'h20080005) begin
            bad++; $display("FAIL fetch_after got ack=%b busy=%b rdata=%h exp=0/0/20080005", bus.if_ack_o, bus.busy_o, bus.if_rdata_o); end
    endtask

    task automatic test_store_load();
        int          we_cycles;
        bit          ack_seen;
        bit          seen;
        logic [31:0] rd;
        we_cycles = 0;
        ack_seen  = 1'b0;
        @(negedge clk);
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h10; bus.d_wdata_i = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 32'h10 || bus.mem_wdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL store_access got we=%b addr=%h wdata=%h exp=1/10/deadbeef", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); end
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_we_o) we_cycles++;
            if (bus.d_ack_o) begin
                ack_seen = 1'b1;
                total++; if (bus.d_rdata_o !== 32'h0) begin bad++; $display("FAIL store_rdata got=%h exp=0", bus.d_rdata_o); end
                bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (we_cycles != 1) begin bad++; $display("FAIL store_we_cycles got=%0d exp=1", we_cycles); end
        total++; if (!ack_seen) begin bad++; $display("FAIL store_ack got=0 exp=1"); end
        total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL store_mem got=%h exp=deadbeef", mem[4]); end
        run_access(1'b1, 1'b0, 32'h10, 32'h0, rd, seen);
        total++; if (!seen || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL load_rdata got seen=%b rdata=%h exp=1/deadbeef", seen, rd); end
    endtask

    task automatic test_starvation();
        bit grants [0:9];
        int n;
        int both;
        n = 0;
        both = 0;
        @(negedge clk);
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h4;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h10;
        for (int i = 0; i < 60 && n < 10; i++) begin
            @(negedge clk);
            if (bus.if_ack_o && bus.d_ack_o) both++;
            if (bus.if_ack_o) begin grants[n] = 1'b1; n++; end
            else if (bus.d_ack_o) begin grants[n] = 1'b0; n++; end
        end
        bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (n != 10) begin bad++; $display("FAIL starve_count got=%0d exp=10", n); end
        total++; if (both != 0) begin bad++; $display("FAIL starve_dual_ack got=%0d exp=0", both); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (grants[i] !== (i % 5 == 4)) begin
                bad++; $display("FAIL starve_grant[%0d] got if=%b exp if=%b", i, grants[i], (i % 5 == 4));
            end
        end
    endtask

    task automatic test_reset_during_store();
        bit          seen;
        logic [31:0] rd;
        @(negedge clk);
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h20; bus.d_wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        total++; if (bus.mem_we_o !== 1'b1) begin bad++; $display("FAIL rst_store_pre_we got=%b exp=1", bus.mem_we_o); end
        rst_n = 1'b0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
        #1;
        total++; if (bus.mem_we_o !== 1'b0) begin bad++; $display("FAIL rst_store_we got=%b exp=0", bus.mem_we_o); end
        @(negedge clk);
        total++; if (bus.busy_o !== 1'b0 || bus.d_ack_o !== 1'b0) begin
            bad++; $display("FAIL rst_store_state got busy=%b ack=%b exp=0/0", bus.busy_o, bus.d_ack_o); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.d_ack_o !== 1'b0) begin bad++; $display("FAIL rst_store_late_ack got=1 exp=0"); end
        end
        run_access(1'b1, 1'b0, 32'h20, 32'h0, rd, seen);
        total++; if (!seen || rd !== 32'h11111111) begin
            bad++; $display("FAIL rst_store_old got seen=%b rdata=%h exp=1/11111111", seen, rd); end
    endtask

`ifdef ACCESS_COUNTER_EN
    task automatic test_counters();
        bit          seen;
        logic [31:0] rd;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run_access(1'b0, 1'b0, 32'h4, 32'h0, rd, seen);
        run_access(1'b1, 1'b0, 32'h10, 32'h0, rd, seen);
        run_access(1'b1, 1'b1, 32'h30, 32'h5, rd, seen);
        total++; if (bus.if_cnt_o !== 32'd3 || bus.d_cnt_o !== 32'd2) begin
            bad++; $display("FAIL counters got if=%0d d=%0d exp=3/2", bus.if_cnt_o, bus.d_cnt_o); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.if_cnt_o !== 32'd0 || bus.d_cnt_o !== 32'd0) begin
            bad++; $display("FAIL counters_reset got if=%0d d=%0d exp=0/0", bus.if_cnt_o, bus.d_cnt_o); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'h20080005;
        mem[8] = 32'h11111111;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_starvation();
        test_reset_during_store();
`ifdef ACCESS_COUNTER_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequencer/arbiter that shares the single-port memory system (instruction + data memory behind one address/write-enable/write-data port) between an instruction-fetch requester and a data load/store requester.
- Grants one access at a time and drives the memory port.
- Captures the combinational read data into a register and returns it with a one-cycle acknowledge pulse.
- Sits between the core's fetch/LSU logic and the memory system.

Parameters:
- DW, 32, data and address width.
- STARVE_LIMIT, 4, maximum number of consecutive data grants while a fetch is pending before fetch is forced; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- if_req_i  input  1  fetch request; held until if_ack_o.
- if_addr_i  input  DW  fetch address.
- if_ack_o  output  1  one-cycle fetch completion pulse.
- if_rdata_o  output  DW  fetched instruction; valid in the ack cycle and held afterwards.
- d_req_i  input  1  data request; held until d_ack_o.
- d_we_i  input  1  1 = store, 0 = load.
- d_addr_i  input  DW  data address.
- d_wdata_i  input  DW  store data.
- d_ack_o  output  1  one-cycle data completion pulse.
- d_rdata_o  output  DW  load data; valid in the ack cycle and held afterwards.
- mem_addr_o  output  DW  memory address.
- mem_we_o  output  1  memory write enable.
- mem_wdata_o  output  DW  memory write data.
- mem_rdata_i  input  DW  memory read data (combinational from mem_addr_o).
- busy_o  output  1  high when the FSM is not IDLE.

Behaviour:
- FSM states are IDLE, ACCESS, RESP. The state register, owner flag (IF/D), latched address/we/wdata, rdata registers and streak counter all reset synchronously when rst_n=0 at a rising edge.
- Reset values:
  - State IDLE; if_ack_o=0; d_ack_o=0; if_rdata_o=0; d_rdata_o=0; busy_o=0.
  - mem_addr_o=0, mem_we_o=0, mem_wdata_o=0; streak counter=0.
- IDLE:
  - No request: stay in IDLE; mem_* outputs are 0.
  - Any request: arbitrate, latch the winner's addr/we/wdata, go to ACCESS.
- Arbitration (IDLE only):
  - Only d_req_i: grant D. Only if_req_i: grant IF.
  - Both: grant IF if streak==STARVE_LIMIT, else grant D.
- Streak counter:
  - +1 on a D grant while if_req_i=1 (saturates at STARVE_LIMIT).
  - Cleared on any IF grant, and on a D grant while if_req_i=0.
- ACCESS (exactly one cycle):
  - mem_addr_o = latched addr; mem_wdata_o = latched wdata (0 for IF).
  - mem_we_o = latched we for D, 0 for IF.
  - At the end of the cycle, capture mem_rdata_i into the owner's rdata register. For a D store, d_rdata_o is NOT updated.
  - Go to RESP.
- RESP (exactly one cycle):
  - Owner's ack = 1 and mem_* outputs = 0.
  - Always return to IDLE. A request still high in RESP is ignored; it is re-sampled in IDLE.
- Latency and throughput:
  - Request sampled high in IDLE at edge k gives ACCESS in cycle k+1 and ack in cycle k+2.
  - Throughput is one access per 3 cycles.
  - Requesters must hold req/addr/we/wdata stable until ack and drop req in the cycle after ack unless issuing a new access.
- Only one ack is ever high. if_ack_o and d_ack_o are never both 1.
- Reset mid-operation:
  - mem_we_o is gated combinationally with rst_n, so a store in ACCESS with rst_n=0 does not write.
  - The pending access is dropped and no ack is issued.
  - Requesters must re-request after reset.
- Unchanged rdata registers hold their value indefinitely.

Optional Feature:
- Macro: ACCESS_COUNTER_EN.
- Defined:
  - Adds outputs if_cnt_o (32) and d_cnt_o (32), counting completed IF and D accesses (incremented in RESP).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1, no requests -> busy_o=0, all mem_* outputs 0, both acks 0, rdata outputs 0.
2. Single fetch: if_req_i=1, if_addr_i=0x00000004, mem_rdata_i returns 0x20080005 -> mem_addr_o=0x4 in cycle k+1, if_ack_o=1 in cycle k+2, if_rdata_o=0x20080005 and held.
3. Store then load: d_we_i=1, d_addr_i=0x10, d_wdata_i=0xDEADBEEF -> mem_we_o=1 for exactly one cycle with those values, d_ack_o pulse, d_rdata_o unchanged. Then a load from 0x10 -> d_rdata_o=0xDEADBEEF.
4. Starvation: if_req_i and d_req_i held continuously (D re-requesting after every ack), STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; fetch never waits more than 4 data accesses.
5. Reset during a store: assert rst_n=0 in the ACCESS cycle of a store to 0x20 -> mem_we_o=0 that cycle, no d_ack_o, state IDLE; a subsequent load from 0x20 returns the old contents.
6. With ACCESS_COUNTER_EN defined: 3 fetches and 2 data accesses -> if_cnt_o=3, d_cnt_o=2; reset clears both to 0.
